// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low {A..G} pattern table, special patterns and FSM state type
package seg7_pkg;
    localparam logic [6:0] SEG7_0 = 7'b0000001;
    localparam logic [6:0] SEG7_1 = 7'b1001111;
    localparam logic [6:0] SEG7_2 = 7'b0010010;
    localparam logic [6:0] SEG7_3 = 7'b0000110;
    localparam logic [6:0] SEG7_4 = 7'b1001100;
    localparam logic [6:0] SEG7_5 = 7'b0100100;
    localparam logic [6:0] SEG7_6 = 7'b0100000;
    localparam logic [6:0] SEG7_7 = 7'b0001111;
    localparam logic [6:0] SEG7_8 = 7'b0000000;
    localparam logic [6:0] SEG7_9 = 7'b0000100;
    localparam logic [6:0] SEG7_A = 7'b0001000;
    localparam logic [6:0] SEG7_B = 7'b1100000;
    localparam logic [6:0] SEG7_C = 7'b0110001;
    localparam logic [6:0] SEG7_D = 7'b1000010;
    localparam logic [6:0] SEG7_E = 7'b0110000;
    localparam logic [6:0] SEG7_F = 7'b0111000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;
    localparam logic [6:0] SEG7_ERR_R = 7'b1111010;
    localparam logic [15:0][6:0] SEG7_TABLE = {SEG7_F, SEG7_E, SEG7_D, SEG7_C, SEG7_B, SEG7_A, SEG7_9, SEG7_8,
                                               SEG7_7, SEG7_6, SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0};
    typedef enum logic [1:0] {IDLE, SETTLE, COMMITTED} seg7_state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: inverse of the hex-to-7-segment table; flags legal codes and blank
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] nibble_o,
    output logic       legal_o,
    output logic       blank_o
);
    always_comb begin
        nibble_o = '0;
        legal_o  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg_n_i == SEG7_TABLE[k]) begin
                nibble_o = 4'(k);
                legal_o  = 1'b1;
            end
        end
    end
    assign blank_o = seg_n_i == SEG7_BLANK;
endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples a multiplexed active-low 7-segment bus, waits for it to settle, decodes per digit.
// Define SEG7_CAPTURE_TIMEOUT_EN to clear a digit's flags when it is not refreshed for TIMEOUT_CYCLES.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   anode_n,
    input  logic [6:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;
    logic [SW-1:0] smp_q, prev_q;
    seg7_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0] valid_q, valid_d, err_q, err_d, sel_oh, tmo_hit;
    logic upd_q, upd_d, sel, same, commit, legal, blank;
    logic [3:0] nibble;
    assign sel_oh = ~smp_q[SW-1:7];
    assign sel    = $onehot(sel_oh);
    assign same   = smp_q == prev_q;
    seg7_pattern_decode u_dec (
        .seg_n_i  (smp_q[6:0]),
        .nibble_o (nibble),
        .legal_o  (legal),
        .blank_o  (blank)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!sel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE || !same) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
        end else if (state_q == SETTLE) begin
            cnt_d   = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
            commit  = cnt_d == CW'(STABLE_CYCLES);
            state_d = commit ? COMMITTED : SETTLE;
        end
    end
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        upd_d    = commit | (|tmo_hit);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (tmo_hit[i]) begin
                valid_d[i] = 1'b0;
                err_d[i]   = 1'b0;
            end
            if (commit && sel_oh[i]) begin
                digits_d[4*i +: 4] = legal ? nibble : digits_q[4*i +: 4];
                valid_d[i]         = legal;
                err_d[i]           = !legal && !blank;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_q    <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            smp_q    <= {anode_n, seg_n};
            prev_q   <= smp_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
        end
    end
`ifdef SEG7_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Counters reset to the expired value so no timeout fires before a digit's first commit.
    logic [NUM_DIGITS-1:0][TW-1:0] tmo_q;
    always_comb begin
        tmo_hit = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            tmo_hit[i] = tmo_q[i] == TW'(TIMEOUT_CYCLES - 1) && !(commit && sel_oh[i]);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                tmo_q[i] <= TW'(TIMEOUT_CYCLES);
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
                tmo_q[i] <= (commit && sel_oh[i]) ? '0 :
                            (tmo_q[i] == TW'(TIMEOUT_CYCLES)) ? tmo_q[i] : tmo_q[i] + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign tmo_hit        = '0;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign update      = upd_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: directed checks of settle/commit, decode flags, multiplexing and reset behaviour.
module tb_seg7_capture_decoder;
    import seg7_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  anode_n = 4'b1111;
    logic [6:0]  seg_n = SEG7_BLANK;
    logic [15:0] digits;
    logic [3:0]  digit_valid, digit_err;
    logic        update;
    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int p0;
    always #5 clk = ~clk;
    seg7_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .reset_n(reset_n), .anode_n(anode_n), .seg_n(seg_n),
        .digits(digits), .digit_valid(digit_valid), .digit_err(digit_err), .update(update)
    );
`ifdef SEG7_CAPTURE_TIMEOUT_EN
    logic [15:0] digits_t;
    logic [3:0]  valid_t, err_t;
    logic        update_t;
    seg7_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset_n(reset_n), .anode_n(anode_n), .seg_n(seg_n),
        .digits(digits_t), .digit_valid(valid_t), .digit_err(err_t), .update(update_t)
    );
`endif
    always @(negedge clk) if (update) npulse++;
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        #2;
        chk("rst_digits", 32'(digits), 0);
        chk("rst_valid", 32'(digit_valid), 0);
        chk("rst_err", 32'(digit_err), 0);
        chk("rst_update", 32'(update), 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        // digit 0 = 2: commit lands on the 5th edge after the pins change
        anode_n = 4'b1110; seg_n = SEG7_2; p0 = npulse;
        tick(4);
        chk("d2_early_update", 32'(update), 0);
        chk("d2_early_valid", 32'(digit_valid), 0);
        tick(1);
        chk("d2_update", 32'(update), 1);
        chk("d2_digits", 32'(digits), 32'h0002);
        chk("d2_valid", 32'(digit_valid), 32'b0001);
        tick(1);
        chk("d2_update_end", 32'(update), 0);
        tick(4);
        chk("d2_pulses", 32'(npulse - p0), 1);
        // toggling every 2 cycles never settles
        p0 = npulse;
        for (int k = 0; k < 10; k++) begin
            seg_n = k[0] ? SEG7_6 : SEG7_5;
            tick(2);
        end
        chk("toggle_pulses", 32'(npulse - p0), 0);
        chk("toggle_digits", 32'(digits), 32'h0002);
        seg_n = SEG7_A;
        tick(5);
        chk("a_update", 32'(update), 1);
        chk("a_digits", 32'(digits), 32'h000A);
        // illegal 'r' on digit 2
        anode_n = 4'b1011; seg_n = SEG7_ERR_R;
        tick(5);
        chk("r_update", 32'(update), 1);
        chk("r_err", 32'(digit_err), 32'b0100);
        chk("r_valid", 32'(digit_valid), 32'b0001);
        chk("r_digits", 32'(digits), 32'h000A);
        tick(2);
        // rotate F,0,7,9 over digits 0..3
        p0 = npulse;
        anode_n = 4'b1110; seg_n = SEG7_F; tick(8);
        anode_n = 4'b1101; seg_n = SEG7_0; tick(8);
        anode_n = 4'b1011; seg_n = SEG7_7; tick(8);
        anode_n = 4'b0111; seg_n = SEG7_9; tick(8);
        chk("rot_digits", 32'(digits), 32'h970F);
        chk("rot_valid", 32'(digit_valid), 32'b1111);
        chk("rot_err", 32'(digit_err), 0);
        chk("rot_pulses", 32'(npulse - p0), 4);
        // two anodes low: no selection, nothing commits
        p0 = npulse;
        anode_n = 4'b1100; seg_n = SEG7_3; tick(10);
        chk("multi_pulses", 32'(npulse - p0), 0);
        chk("multi_digits", 32'(digits), 32'h970F);
        // blank on digit 3: nibble kept, valid and err cleared
        anode_n = 4'b0111; seg_n = SEG7_BLANK; tick(5);
        chk("blank_update", 32'(update), 1);
        chk("blank_valid", 32'(digit_valid), 32'b0111);
        chk("blank_err", 32'(digit_err), 0);
        chk("blank_digits", 32'(digits), 32'h970F);
        tick(2);
        // reset while settling discards the partial count
        anode_n = 4'b1101; seg_n = SEG7_8; tick(3);
        reset_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(digits), 0);
        chk("midrst_valid", 32'(digit_valid), 0);
        chk("midrst_err", 32'(digit_err), 0);
        chk("midrst_update", 32'(update), 0);
        tick(3);
        chk("inrst_update", 32'(update), 0);
        reset_n = 1'b1;
        tick(4);
        chk("rel_early_valid", 32'(digit_valid), 0);
        tick(1);
        chk("rel_digits", 32'(digits), 32'h0080);
        chk("rel_valid", 32'(digit_valid), 32'b0010);
`ifdef SEG7_CAPTURE_TIMEOUT_EN
        chk("tmo_commit", 32'(valid_t), 32'b0010);
        anode_n = 4'b1111;
        tick(15);
        chk("tmo_before", 32'(valid_t), 32'b0010);
        chk("tmo_before_upd", 32'(update_t), 0);
        tick(1);
        chk("tmo_valid", 32'(valid_t), 0);
        chk("tmo_update", 32'(update_t), 1);
        chk("tmo_digits", 32'(digits_t), 32'h0080);
        tick(1);
        chk("tmo_update_end", 32'(update_t), 0);
        tick(20);
        chk("tmo_hold_upd", 32'(update_t), 0);
        chk("tmo_hold_valid", 32'(valid_t), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
